// File: rtl/decode_stage_nway.sv
// N-way RV64 decode stage: per-lane field decode, regfile read addressing and data capture,
// behind a valid/ready handshake with an output register plus one skid register.
module decode_stage_nway #(
   parameter int unsigned WAYS  = 2,
   parameter int unsigned XLEN  = 64,
   parameter int unsigned PID_W = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    flush_i,
   input  logic                    valid_i,
   output logic                    ready_o,
   input  logic [WAYS-1:0]         wayValid_i,
   input  logic [32*WAYS-1:0]      inst_i,
   input  logic [PID_W*WAYS-1:0]   pID_i,
   output logic [5*WAYS-1:0]       rs1Addr_o,
   output logic [5*WAYS-1:0]       rs2Addr_o,
   output logic [WAYS-1:0]         rs1ReadEnable_o,
   output logic [WAYS-1:0]         rs2ReadEnable_o,
   input  logic [XLEN*WAYS-1:0]    rs1ReadData_i,
   input  logic [XLEN*WAYS-1:0]    rs2ReadData_i,
   output logic                    valid_o,
   input  logic                    ready_i,
   output logic [WAYS-1:0]         wayValid_o,
   output logic [7*WAYS-1:0]       opCode_o,
   output logic [3*WAYS-1:0]       funct3_o,
   output logic [7*WAYS-1:0]       funct7_o,
   output logic [5*WAYS-1:0]       rdAddr_o,
   output logic [WAYS-1:0]         rdWriteEnable_o,
   output logic [WAYS-1:0]         isLoad_o,
   output logic [WAYS-1:0]         illegal_o,
   output logic [XLEN*WAYS-1:0]    imm_o,
   output logic [6*WAYS-1:0]       shamt_o,
   output logic [XLEN*WAYS-1:0]    rs1ReadData_o,
   output logic [XLEN*WAYS-1:0]    rs2ReadData_o,
   output logic [PID_W*WAYS-1:0]   pID_o
);

   localparam logic [6:0] OpLui    = 7'b0110111;
   localparam logic [6:0] OpAuipc  = 7'b0010111;
   localparam logic [6:0] OpJal    = 7'b1101111;
   localparam logic [6:0] OpJalr   = 7'b1100111;
   localparam logic [6:0] OpBranch = 7'b1100011;
   localparam logic [6:0] OpLoad   = 7'b0000011;
   localparam logic [6:0] OpStore  = 7'b0100011;
   localparam logic [6:0] OpImm    = 7'b0010011;
   localparam logic [6:0] OpReg    = 7'b0110011;
   localparam logic [6:0] OpSystem = 7'b1110011;
   localparam logic [6:0] OpImm32  = 7'b0011011;
   localparam logic [6:0] OpReg32  = 7'b0111011;
   localparam logic [6:0] OpAmo    = 7'b0101111;
   localparam logic [6:0] OpFp     = 7'b1010011;

   typedef struct packed {
      logic             valid;
      logic [6:0]       opcode;
      logic [2:0]       funct3;
      logic [6:0]       funct7;
      logic [4:0]       rd;
      logic             rd_we;
      logic             is_load;
      logic             illegal;
      logic [XLEN-1:0]  imm;
      logic [5:0]       shamt;
      logic [XLEN-1:0]  rs1_data;
      logic [XLEN-1:0]  rs2_data;
      logic [PID_W-1:0] pid;
   } lane_t;

   lane_t dec_lane [WAYS];
   lane_t out_q    [WAYS];
   lane_t skid_q   [WAYS];

   logic out_valid_q, out_valid_d;
   logic skid_valid_q, skid_valid_d;
   logic ready_q, ready_d;
   logic accept, out_free, load_out, load_skid, out_sel_skid;

   for (genvar k = 0; k < WAYS; k++) begin : g_lane
      logic [31:0]     ins;
      logic [6:0]      op;
      logic [2:0]      f3;
      logic            csr, legal, use_rs1, use_rs2, writer, we, ld;
      logic [XLEN-1:0] imm, i_imm, s_imm, b_imm, j_imm, u_imm;
      logic [5:0]      shamt;
      lane_t           lane_d;

      assign ins   = inst_i[32*k +: 32];
      assign op    = ins[6:0];
      assign f3    = ins[14:12];
      assign csr   = (f3 != 3'b000) && (f3 != 3'b100);
      assign i_imm = {{(XLEN-12){ins[31]}}, ins[31:20]};
      assign s_imm = {{(XLEN-12){ins[31]}}, ins[31:25], ins[11:7]};
      assign b_imm = {{(XLEN-13){ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      assign j_imm = {{(XLEN-21){ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      assign u_imm = {{(XLEN-32){ins[31]}}, ins[31:12], 12'b0};

      always_comb begin
         legal   = 1'b1;
         use_rs1 = 1'b0;
         use_rs2 = 1'b0;
         writer  = 1'b0;
         we      = 1'b0;
         ld      = 1'b0;
         imm     = '0;
         shamt   = '0;
         case (op)
            OpLui, OpAuipc: begin writer = 1'b1; we = 1'b1; imm = u_imm; end
            OpJal:    begin writer = 1'b1; we = 1'b1; imm = j_imm; end
            OpJalr:   begin use_rs1 = 1'b1; writer = 1'b1; we = 1'b1; imm = i_imm; end
            OpBranch: begin use_rs1 = 1'b1; use_rs2 = 1'b1; imm = b_imm; end
            OpLoad:   begin use_rs1 = 1'b1; writer = 1'b1; ld = 1'b1; imm = i_imm; end
            OpStore:  begin use_rs1 = 1'b1; use_rs2 = 1'b1; imm = s_imm; end
            OpImm: begin
               use_rs1 = 1'b1;
               writer  = 1'b1;
               we      = 1'b1;
               imm     = i_imm;
               if ((f3 == 3'b001 && ins[31:26] == 6'b000000) ||
                   (f3 == 3'b101 && (ins[31:26] == 6'b000000 || ins[31:26] == 6'b010000))) begin
                  shamt = ins[25:20];
               end
            end
            OpImm32:  begin use_rs1 = 1'b1; writer = 1'b1; we = 1'b1; imm = i_imm; end
            // M-extension results return through a later writeback path
            OpReg, OpReg32: begin
               use_rs1 = 1'b1;
               use_rs2 = 1'b1;
               writer  = 1'b1;
               we      = (ins[31:25] != 7'b0000001);
            end
            OpSystem: begin use_rs1 = csr; writer = csr; we = csr; imm = i_imm; end
            OpAmo, OpFp: begin use_rs1 = 1'b1; use_rs2 = 1'b1; writer = 1'b1; we = 1'b1; end
            default:  legal = 1'b0;
         endcase
      end

      always_comb begin
         lane_d = '0;
         if (wayValid_i[k]) begin
            lane_d.valid    = 1'b1;
            lane_d.opcode   = op;
            lane_d.funct3   = f3;
            lane_d.funct7   = ins[31:25];
            lane_d.rd       = writer ? ins[11:7] : 5'd0;
            lane_d.rd_we    = we;
            lane_d.is_load  = ld;
            lane_d.illegal  = !legal;
            lane_d.imm      = imm;
            lane_d.shamt    = shamt;
            lane_d.rs1_data = rs1ReadData_i[XLEN*k +: XLEN];
            lane_d.rs2_data = rs2ReadData_i[XLEN*k +: XLEN];
            lane_d.pid      = pID_i[PID_W*k +: PID_W];
         end
      end

      assign dec_lane[k]             = lane_d;
      assign rs1ReadEnable_o[k]      = wayValid_i[k] && use_rs1;
      assign rs2ReadEnable_o[k]      = wayValid_i[k] && use_rs2;
      assign rs1Addr_o[5*k +: 5]     = (wayValid_i[k] && use_rs1) ? ins[19:15] : 5'd0;
      assign rs2Addr_o[5*k +: 5]     = (wayValid_i[k] && use_rs2) ? ins[24:20] : 5'd0;

      assign wayValid_o[k]               = out_q[k].valid;
      assign opCode_o[7*k +: 7]          = out_q[k].opcode;
      assign funct3_o[3*k +: 3]          = out_q[k].funct3;
      assign funct7_o[7*k +: 7]          = out_q[k].funct7;
      assign rdAddr_o[5*k +: 5]          = out_q[k].rd;
      assign rdWriteEnable_o[k]          = out_q[k].rd_we;
      assign isLoad_o[k]                 = out_q[k].is_load;
      assign illegal_o[k]                = out_q[k].illegal;
      assign imm_o[XLEN*k +: XLEN]       = out_q[k].imm;
      assign shamt_o[6*k +: 6]           = out_q[k].shamt;
      assign rs1ReadData_o[XLEN*k +: XLEN] = out_q[k].rs1_data;
      assign rs2ReadData_o[XLEN*k +: XLEN] = out_q[k].rs2_data;
      assign pID_o[PID_W*k +: PID_W]     = out_q[k].pid;
   end

   // ready only reflects skid occupancy, so it never depends on ready_i combinationally
   always_comb begin
      accept       = valid_i && ready_q && !flush_i;
      out_free     = !out_valid_q || ready_i;
      out_valid_d  = out_valid_q;
      skid_valid_d = skid_valid_q;
      load_out     = 1'b0;
      load_skid    = 1'b0;
      out_sel_skid = 1'b0;
      if (flush_i) begin
         out_valid_d  = 1'b0;
         skid_valid_d = 1'b0;
      end else if (out_free) begin
         if (skid_valid_q) begin
            load_out     = 1'b1;
            out_sel_skid = 1'b1;
            out_valid_d  = 1'b1;
            skid_valid_d = 1'b0;
         end else if (accept) begin
            load_out    = 1'b1;
            out_valid_d = 1'b1;
         end else begin
            out_valid_d = 1'b0;
         end
      end else if (accept) begin
         load_skid    = 1'b1;
         skid_valid_d = 1'b1;
      end
      ready_d = !skid_valid_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q  <= 1'b0;
         skid_valid_q <= 1'b0;
         ready_q      <= 1'b1;
         for (int k = 0; k < WAYS; k++) begin
            out_q[k]  <= '0;
            skid_q[k] <= '0;
         end
      end else begin
         out_valid_q  <= out_valid_d;
         skid_valid_q <= skid_valid_d;
         ready_q      <= ready_d;
         for (int k = 0; k < WAYS; k++) begin
            if (load_out) out_q[k] <= out_sel_skid ? skid_q[k] : dec_lane[k];
            if (load_skid) skid_q[k] <= dec_lane[k];
         end
      end
   end

   assign valid_o = out_valid_q;
   assign ready_o = ready_q;

endmodule

// File: tb/tb_decode_stage_nway.sv
// Scoreboard bench for decode_stage_nway (WAYS=2): directed bundles, backpressure, flush, reset.
module tb_decode_stage_nway;

   localparam int unsigned WAYS = 2;
   localparam int unsigned XLEN = 64;
   localparam int unsigned PID_W = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic flush_i = 1'b0;
   logic valid_i = 1'b0;
   logic ready_o;
   logic [WAYS-1:0] wayValid_i = '0;
   logic [32*WAYS-1:0] inst_i = '0;
   logic [PID_W*WAYS-1:0] pID_i = '0;
   logic [5*WAYS-1:0] rs1Addr_o, rs2Addr_o;
   logic [WAYS-1:0] rs1ReadEnable_o, rs2ReadEnable_o;
   logic [XLEN*WAYS-1:0] rs1ReadData_i, rs2ReadData_i;
   logic valid_o;
   logic ready_i = 1'b0;
   logic [WAYS-1:0] wayValid_o;
   logic [7*WAYS-1:0] opCode_o, funct7_o;
   logic [3*WAYS-1:0] funct3_o;
   logic [5*WAYS-1:0] rdAddr_o;
   logic [WAYS-1:0] rdWriteEnable_o, isLoad_o, illegal_o;
   logic [XLEN*WAYS-1:0] imm_o, rs1ReadData_o, rs2ReadData_o;
   logic [6*WAYS-1:0] shamt_o;
   logic [PID_W*WAYS-1:0] pID_o;

   // Regfile model: x[n] reads as A000+n on port 1 and B000+n on port 2
   assign rs1ReadData_i = {64'hA000 + 64'(rs1Addr_o[9:5]), 64'hA000 + 64'(rs1Addr_o[4:0])};
   assign rs2ReadData_i = {64'hB000 + 64'(rs2Addr_o[9:5]), 64'hB000 + 64'(rs2Addr_o[4:0])};

   always #5 clk = ~clk;

   decode_stage_nway #(.WAYS(WAYS), .XLEN(XLEN), .PID_W(PID_W)) dut (
      .clk(clk), .rst(rst), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_o),
      .wayValid_i(wayValid_i), .inst_i(inst_i), .pID_i(pID_i),
      .rs1Addr_o(rs1Addr_o), .rs2Addr_o(rs2Addr_o),
      .rs1ReadEnable_o(rs1ReadEnable_o), .rs2ReadEnable_o(rs2ReadEnable_o),
      .rs1ReadData_i(rs1ReadData_i), .rs2ReadData_i(rs2ReadData_i),
      .valid_o(valid_o), .ready_i(ready_i), .wayValid_o(wayValid_o),
      .opCode_o(opCode_o), .funct3_o(funct3_o), .funct7_o(funct7_o), .rdAddr_o(rdAddr_o),
      .rdWriteEnable_o(rdWriteEnable_o), .isLoad_o(isLoad_o), .illegal_o(illegal_o),
      .imm_o(imm_o), .shamt_o(shamt_o), .rs1ReadData_o(rs1ReadData_o),
      .rs2ReadData_o(rs2ReadData_o), .pID_o(pID_o)
   );

   typedef struct packed {
      logic [6:0]  op;
      logic [4:0]  rd;
      logic        we;
      logic        ld;
      logic        ill;
      logic [63:0] imm;
      logic [5:0]  sh;
      logic [63:0] d1;
      logic [63:0] d2;
      logic [1:0]  pid;
   } lane_t;

   typedef struct packed {
      logic       e1;
      logic       e2;
      logic [4:0] a1;
      logic [4:0] a2;
   } rs_t;

   typedef struct packed {
      logic [1:0] wv;
      lane_t      l1;
      lane_t      l0;
   } bundle_t;

   bundle_t sb[$];
   bundle_t mon_e;
   int total = 0;
   int bad = 0;

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic lane_t mk(input logic [6:0] op, input logic [4:0] rd, input logic we,
                                input logic ld, input logic ill, input logic [63:0] imm,
                                input logic [5:0] sh, input logic [4:0] a1, input logic [4:0] a2,
                                input logic [1:0] pid);
      lane_t l;
      l.op = op; l.rd = rd; l.we = we; l.ld = ld; l.ill = ill; l.imm = imm; l.sh = sh;
      l.d1 = 64'hA000 + 64'(a1);
      l.d2 = 64'hB000 + 64'(a2);
      l.pid = pid;
      return l;
   endfunction

   function automatic rs_t mkrs(input logic e1, input logic [4:0] a1, input logic e2,
                                input logic [4:0] a2);
      rs_t r;
      r.e1 = e1; r.a1 = a1; r.e2 = e2; r.a2 = a2;
      return r;
   endfunction

   function automatic lane_t act_lane(input int k);
      lane_t l;
      l.op  = opCode_o[7*k +: 7];
      l.rd  = rdAddr_o[5*k +: 5];
      l.we  = rdWriteEnable_o[k];
      l.ld  = isLoad_o[k];
      l.ill = illegal_o[k];
      l.imm = imm_o[64*k +: 64];
      l.sh  = shamt_o[6*k +: 6];
      l.d1  = rs1ReadData_o[64*k +: 64];
      l.d2  = rs2ReadData_o[64*k +: 64];
      l.pid = pID_o[2*k +: 2];
      return l;
   endfunction

   function automatic rs_t act_rs(input int k);
      rs_t r;
      r.e1 = rs1ReadEnable_o[k]; r.e2 = rs2ReadEnable_o[k];
      r.a1 = rs1Addr_o[5*k +: 5]; r.a2 = rs2Addr_o[5*k +: 5];
      return r;
   endfunction

   // Called just after a rising edge; holds valid_i until the bundle is accepted
   task automatic send(input logic [31:0] i0, input logic [31:0] i1, input logic [1:0] wv,
                       input logic [1:0] p0, input logic [1:0] p1, input rs_t r0, input rs_t r1,
                       input lane_t l0, input lane_t l1, input bit push);
      bit acc;
      bit done = 1'b0;
      bundle_t b;
      inst_i = {i1, i0};
      wayValid_i = wv;
      pID_i = {p1, p0};
      valid_i = 1'b1;
      #1;
      chk("rs_lane0", act_rs(0), r0);
      chk("rs_lane1", act_rs(1), r1);
      for (int n = 0; n < 20; n++) begin
         acc = ready_o;
         @(posedge clk);
         #1;
         if (acc) begin
            done = 1'b1;
            break;
         end
      end
      valid_i = 1'b0;
      chk("accept_timeout", done, 1'b1);
      if (done && push) begin
         b.wv = wv; b.l0 = l0; b.l1 = l1;
         sb.push_back(b);
      end
   endtask

   always @(negedge clk) begin
      if (!rst && valid_o && ready_i) begin
         if (sb.size() == 0) begin
            chk("unexpected_output", valid_o, 1'b0);
         end else begin
            mon_e = sb.pop_front();
            chk("way_valid", wayValid_o, mon_e.wv);
            chk("lane0", act_lane(0), mon_e.l0);
            chk("lane1", act_lane(1), mon_e.l1);
         end
      end
   end

   initial begin
      lane_t z;
      rs_t rz;
      z = '0;
      rz = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      chk("reset_valid_o", valid_o, 1'b0);
      chk("reset_ready_o", ready_o, 1'b1);
      chk("reset_imm", imm_o, '0);

      ready_i = 1'b1;
      // addi x1,x0,5 | srai x1,x1,63
      send(32'h00500093, 32'h43F0D093, 2'b11, 2'd1, 2'd2,
           mkrs(1, 0, 0, 0), mkrs(1, 1, 0, 0),
           mk(7'h13, 1, 1, 0, 0, 64'd5, 6'd0, 0, 0, 2'd1),
           mk(7'h13, 1, 1, 0, 0, 64'h43F, 6'd63, 1, 0, 2'd2), 1'b1);
      // beq x1,x2,-4 | lane1 absent
      send(32'hFE208EE3, 32'h00500093, 2'b01, 2'd3, 2'd1,
           mkrs(1, 1, 1, 2), rz,
           mk(7'h63, 0, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFC, 6'd0, 1, 2, 2'd3), z, 1'b1);
      // all-zero (illegal) | ld x1,0(x1)
      send(32'h00000000, 32'h0000B083, 2'b11, 2'd0, 2'd1,
           rz, mkrs(1, 1, 0, 0),
           mk(7'h00, 0, 0, 0, 1, 64'd0, 6'd0, 0, 0, 2'd0),
           mk(7'h03, 1, 0, 1, 0, 64'd0, 6'd0, 1, 0, 2'd1), 1'b1);
      // lui x1,0x12345 | lui x2,0xFFFFF
      send(32'h123450B7, 32'hFFFFF137, 2'b11, 2'd2, 2'd3, rz, rz,
           mk(7'h37, 1, 1, 0, 0, 64'h12345000, 6'd0, 0, 0, 2'd2),
           mk(7'h37, 2, 1, 0, 0, 64'hFFFF_FFFF_FFFF_F000, 6'd0, 0, 0, 2'd3), 1'b1);
      // sd x2,-1(x1) | mul x3,x1,x2
      send(32'hFE20BFA3, 32'h022081B3, 2'b11, 2'd0, 2'd1,
           mkrs(1, 1, 1, 2), mkrs(1, 1, 1, 2),
           mk(7'h23, 0, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 6'd0, 1, 2, 2'd0),
           mk(7'h33, 3, 0, 0, 0, 64'd0, 6'd0, 1, 2, 2'd1), 1'b1);
      // csrrw x5,0x300,x1 | ecall
      send(32'h300092F3, 32'h00000073, 2'b11, 2'd2, 2'd3,
           mkrs(1, 1, 0, 0), rz,
           mk(7'h73, 5, 1, 0, 0, 64'h300, 6'd0, 1, 0, 2'd2),
           mk(7'h73, 0, 0, 0, 0, 64'd0, 6'd0, 0, 0, 2'd3), 1'b1);
      repeat (3) @(posedge clk);
      #1;

      // Backpressure: A to output, B to skid, C held off until the stall clears
      ready_i = 1'b0;
      send(32'h123450B7, 32'hFFFFF137, 2'b11, 2'd2, 2'd3, rz, rz,
           mk(7'h37, 1, 1, 0, 0, 64'h12345000, 6'd0, 0, 0, 2'd2),
           mk(7'h37, 2, 1, 0, 0, 64'hFFFF_FFFF_FFFF_F000, 6'd0, 0, 0, 2'd3), 1'b1);
      send(32'hFE20BFA3, 32'h022081B3, 2'b11, 2'd0, 2'd1,
           mkrs(1, 1, 1, 2), mkrs(1, 1, 1, 2),
           mk(7'h23, 0, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 6'd0, 1, 2, 2'd0),
           mk(7'h33, 3, 0, 0, 0, 64'd0, 6'd0, 1, 2, 2'd1), 1'b1);
      chk("bp_ready_low", ready_o, 1'b0);
      chk("bp_valid_high", valid_o, 1'b1);
      inst_i = {32'h00000073, 32'h300092F3};
      valid_i = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("bp_ready_still_low", ready_o, 1'b0);
      chk("bp_holds_a_imm", imm_o[63:0], 64'h12345000);
      ready_i = 1'b1;
      send(32'h300092F3, 32'h00000073, 2'b11, 2'd2, 2'd3,
           mkrs(1, 1, 0, 0), rz,
           mk(7'h73, 5, 1, 0, 0, 64'h300, 6'd0, 1, 0, 2'd2),
           mk(7'h73, 0, 0, 0, 0, 64'd0, 6'd0, 0, 0, 2'd3), 1'b1);
      repeat (3) @(posedge clk);
      #1;
      chk("bp_drained", sb.size(), 0);

      // Flush with output and skid both full and a new bundle arriving
      ready_i = 1'b0;
      send(32'h00500093, 32'h43F0D093, 2'b11, 2'd1, 2'd2,
           mkrs(1, 0, 0, 0), mkrs(1, 1, 0, 0), z, z, 1'b0);
      send(32'h0000B083, 32'h0000B083, 2'b11, 2'd0, 2'd0,
           mkrs(1, 1, 0, 0), mkrs(1, 1, 0, 0), z, z, 1'b0);
      chk("fl_ready_low", ready_o, 1'b0);
      flush_i = 1'b1;
      valid_i = 1'b1;
      @(posedge clk);
      #1;
      flush_i = 1'b0;
      valid_i = 1'b0;
      chk("fl_valid_o", valid_o, 1'b0);
      chk("fl_ready_o", ready_o, 1'b1);
      ready_i = 1'b1;
      repeat (4) @(posedge clk);
      #1;

      // Reset while stalled on a held bundle
      ready_i = 1'b0;
      send(32'h300092F3, 32'h123450B7, 2'b11, 2'd2, 2'd3,
           mkrs(1, 1, 0, 0), rz, z, z, 1'b0);
      chk("rs_pre_valid", valid_o, 1'b1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("rs_valid_o", valid_o, 1'b0);
      chk("rs_ready_o", ready_o, 1'b1);
      chk("rs_imm", imm_o, '0);
      chk("rs_rd", rdAddr_o, '0);
      chk("rs_wv_pid", {wayValid_o, pID_o, rdWriteEnable_o}, '0);
      chk("rs_data", {rs1ReadData_o, rs2ReadData_o}, '0);
      ready_i = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("scoreboard_empty", sb.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
